// File: rtl/pc_redirect_controller.sv
// pc_redirect_controller
//   Control sequencer for the stage-1 PC incrementer. Arbitrates hazard
//   stall, taken branch (PC-relative) and jump (absolute) requests. A
//   redirect that arrives during a stall is held until the stall releases.
//   Wrong-path fetches are squashed after every applied redirect. The PC is
//   held frozen for BOOT_CYCLES cycles after reset.
//
// Parameters:
//   BOOT_CYCLES  (1..15) cycles PCWrite stays low after reset release
//   FLUSH_CYCLES (1..15) cycles Flush stays high after a redirect
//   WIDTH        PC / offset / address width
//
// Ports:
//   CLK, RST_N        clock, synchronous active-low reset
//   StallReq          hazard stall, PC must not change
//   BranchReq/Offset  taken branch and sign-extended offset
//   JumpReq/JumpAddr  jump and absolute target
//   PCWrite, PCAdd, PCSource, PCAddFromSE, PCSourceFromValA
//                     PC unit controls/operands (Mealy, applied same edge)
//   Flush             squash stage-1/2 instruction registers
//   Pending           a redirect is held awaiting stall release
//
// Optional build macro PC_REDIRECT_STATS_EN adds saturating 16-bit
// RedirectCount and IgnoredCount outputs.
module pc_redirect_controller #(
    parameter int unsigned BOOT_CYCLES  = 2,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned WIDTH        = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             StallReq,
    input  logic             BranchReq,
    input  logic [WIDTH-1:0] BranchOffset,
    input  logic             JumpReq,
    input  logic [WIDTH-1:0] JumpAddr,
    output logic             PCWrite,
    output logic             PCAdd,
    output logic             PCSource,
    output logic [WIDTH-1:0] PCAddFromSE,
    output logic [WIDTH-1:0] PCSourceFromValA,
    output logic             Flush,
    output logic             Pending
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [15:0]      RedirectCount,
    output logic [15:0]      IgnoredCount
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, PEND, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             pjmp_q, pjmp_d;   // stored redirect is a jump
    logic [WIDTH-1:0] pop_q, pop_d;     // stored operand (offset or target)
    logic             redirect;

    assign redirect = JumpReq | BranchReq;
    assign Pending  = (state_q == PEND);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= BOOT;
            cnt_q   <= '0;
            pjmp_q  <= 1'b0;
            pop_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pjmp_q  <= pjmp_d;
            pop_q   <= pop_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        pjmp_d           = pjmp_q;
        pop_d            = pop_q;
        PCWrite          = 1'b0;
        PCAdd            = 1'b0;
        PCSource         = 1'b0;
        PCAddFromSE      = '0;
        PCSourceFromValA = '0;
        Flush            = 1'b0;
        case (state_q)
            BOOT: begin
                if (cnt_q == 4'(BOOT_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RUN: begin
                if (!StallReq) begin
                    PCWrite = 1'b1;
                    if (JumpReq) begin
                        PCSource         = 1'b1;
                        PCSourceFromValA = JumpAddr;
                        state_d          = FLUSH;
                        cnt_d            = '0;
                    end else if (BranchReq) begin
                        PCAdd       = 1'b1;
                        PCAddFromSE = BranchOffset;
                        state_d     = FLUSH;
                        cnt_d       = '0;
                    end
                end else if (redirect) begin
                    pjmp_d  = JumpReq;
                    pop_d   = JumpReq ? JumpAddr : BranchOffset;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (StallReq) begin
                    // Only a jump may displace a held branch; everything else
                    // is dropped so the first captured redirect wins.
                    if (JumpReq && !pjmp_q) begin
                        pjmp_d = 1'b1;
                        pop_d  = JumpAddr;
                    end
                end else begin
                    // Live request inputs are deliberately ignored here.
                    PCWrite = 1'b1;
                    if (pjmp_q) begin
                        PCSource         = 1'b1;
                        PCSourceFromValA = pop_q;
                    end else begin
                        PCAdd       = 1'b1;
                        PCAddFromSE = pop_q;
                    end
                    pjmp_d  = 1'b0;
                    pop_d   = '0;
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                Flush = 1'b1;
                if (!StallReq) begin
                    PCWrite = 1'b1;
                    if (cnt_q == 4'(FLUSH_CYCLES - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = BOOT;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef PC_REDIRECT_STATS_EN
    logic applied, dropped;

    assign applied = ((state_q == RUN) && !StallReq && redirect) ||
                     ((state_q == PEND) && !StallReq);
    // In PEND any request cycle loses something: either the new request or
    // the branch it overrides.
    assign dropped = redirect && ((state_q == BOOT) || (state_q == FLUSH) ||
                                  (state_q == PEND));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            RedirectCount <= '0;
            IgnoredCount  <= '0;
        end else begin
            if (applied && (RedirectCount != '1))
                RedirectCount <= RedirectCount + 16'd1;
            if (dropped && (IgnoredCount != '1))
                IgnoredCount <= IgnoredCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Directed bench for pc_redirect_controller. A small PC-unit register is
// driven by the DUT controls; expected controls for each cycle are queued
// when the stimulus is applied and popped when the outputs are sampled.
module tb_pc_redirect_controller;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        StallReq, BranchReq, JumpReq;
    logic [15:0] BranchOffset, JumpAddr;
    logic        PCWrite, PCAdd, PCSource, Flush, Pending;
    logic [15:0] PCAddFromSE, PCSourceFromValA;
`ifdef PC_REDIRECT_STATS_EN
    logic [15:0] RedirectCount, IgnoredCount;
    logic [15:0] r0, i0;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        pcw, add, src;
        logic [15:0] se, va;
        logic        fl, pd;
    } exp_t;

    exp_t sb[$];
    logic [15:0] pc;

    always #5 CLK = ~CLK;

    pc_redirect_controller #(.BOOT_CYCLES(2), .FLUSH_CYCLES(2), .WIDTH(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .StallReq(StallReq), .BranchReq(BranchReq),
        .BranchOffset(BranchOffset), .JumpReq(JumpReq), .JumpAddr(JumpAddr),
        .PCWrite(PCWrite), .PCAdd(PCAdd), .PCSource(PCSource),
        .PCAddFromSE(PCAddFromSE), .PCSourceFromValA(PCSourceFromValA),
        .Flush(Flush), .Pending(Pending)
`ifdef PC_REDIRECT_STATS_EN
        , .RedirectCount(RedirectCount), .IgnoredCount(IgnoredCount)
`endif
    );

    // PC unit: PCSource beats PCAdd, otherwise PC+1; wraps mod 2^16.
    always_ff @(posedge CLK) begin
        if (!RST_N) pc <= '0;
        else if (PCWrite) pc <= PCSource ? PCSourceFromValA :
                                PCAdd ? pc + PCAddFromSE : pc + 16'd1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic pcw, add, src, input logic [15:0] se, va,
                                input logic fl, pd);
        exp_t e;
        e.pcw = pcw; e.add = add; e.src = src; e.se = se; e.va = va; e.fl = fl; e.pd = pd;
        return e;
    endfunction

    // Drive one cycle of requests, queue its expectation, compare, advance.
    task automatic step(input string tag, input logic s, b, input logic [15:0] off,
                        input logic j, input logic [15:0] a, input exp_t e);
        exp_t g;
        StallReq = s; BranchReq = b; BranchOffset = off; JumpReq = j; JumpAddr = a;
        sb.push_back(e);
        #2;
        g = sb.pop_front();
        chk({tag, ".PCWrite"}, 16'(PCWrite), 16'(g.pcw));
        chk({tag, ".PCAdd"}, 16'(PCAdd), 16'(g.add));
        chk({tag, ".PCSource"}, 16'(PCSource), 16'(g.src));
        chk({tag, ".PCAddFromSE"}, PCAddFromSE, g.se);
        chk({tag, ".PCSourceFromValA"}, PCSourceFromValA, g.va);
        chk({tag, ".Flush"}, 16'(Flush), 16'(g.fl));
        chk({tag, ".Pending"}, 16'(Pending), 16'(g.pd));
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RST_N = 1'b0; StallReq = 0; BranchReq = 0; JumpReq = 0;
        BranchOffset = '0; JumpAddr = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        step("reset", 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
`ifdef PC_REDIRECT_STATS_EN
        chk("reset_rc", RedirectCount, 16'd0);
        chk("reset_ic", IgnoredCount, 16'd0);
`endif
        RST_N = 1'b1;
        // Requests during boot are ignored.
        step("boot0", 0, 1, 16'd7, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
        step("boot1", 0, 0, 0, 1, 16'd9, mk(0, 0, 0, 0, 0, 0, 0));
        chk("pc_after_boot", pc, 16'd0);
        for (int i = 0; i < 32; i++)
            step("run", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        chk("pc_count32", pc, 16'd32);

        // Branch +255
        step("br", 0, 1, 16'd255, 0, 0, mk(1, 1, 0, 16'd255, 0, 0, 0));
        chk("pc_br", pc, 16'd287);
        step("br_fl0", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 1, 0));
        step("br_fl1", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 1, 0));
        step("br_run", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        chk("pc_br_resume", pc, 16'd290);

        // Jump beats branch
        step("jb", 0, 1, 16'd255, 1, 16'd302, mk(1, 0, 1, 0, 16'd302, 0, 0));
        chk("pc_jump", pc, 16'd302);
        step("jb_fl0", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 1, 0));
        step("jb_fl1", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 1, 0));
        step("jb_run", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        chk("pc_jb_resume", pc, 16'd305);

        // Stalled branch overridden by a jump
        step("st0", 1, 1, 16'd16, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
        step("st1", 1, 0, 0, 1, 16'd500, mk(0, 0, 0, 0, 0, 0, 1));
        step("st2", 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
        chk("pc_stalled", pc, 16'd305);
        step("st_rel", 0, 1, 16'd3, 0, 0, mk(1, 0, 1, 0, 16'd500, 0, 1));
        chk("pc_st_jump", pc, 16'd500);
        step("st_fl0", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 1, 0));
        step("st_fl1", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 1, 0));
        step("st_run", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        chk("pc_st_resume", pc, 16'd503);

        // Jump during flush is ignored; a stall holds the flush counter.
`ifdef PC_REDIRECT_STATS_EN
        r0 = RedirectCount; i0 = IgnoredCount;
`endif
        step("ig_br", 0, 1, 16'd4, 0, 0, mk(1, 1, 0, 16'd4, 0, 0, 0));
        step("ig_j", 0, 0, 0, 1, 16'd302, mk(1, 0, 0, 0, 0, 1, 0));
        step("ig_st", 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0));
        step("ig_fl1", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 1, 0));
        step("ig_run", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        chk("pc_ig", pc, 16'd510);
`ifdef PC_REDIRECT_STATS_EN
        chk("ig_rc_delta", RedirectCount - r0, 16'd1);
        chk("ig_ic_delta", IgnoredCount - i0, 16'd1);
`endif

        // Reset while a redirect is pending
        step("rp0", 1, 1, 16'd8, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
        step("rp1", 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
        RST_N = 1'b0;
        step("rp_rst", 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
        RST_N = 1'b1;
        step("rp_boot0", 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
        step("rp_boot1", 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            step("rp_run", 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        chk("pc_after_rp", pc, 16'd3);
`ifdef PC_REDIRECT_STATS_EN
        chk("rp_rc", RedirectCount, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
